// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default timing constants and helpers.
// Imported by both the transmitter and the receiver so their defaults loop back directly.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // 9600 baud from a 10 MHz clock; the half rate centres the receiver's sample point.
    localparam int unsigned BAUD_RATE_DEF      = 1042;
    localparam int unsigned HALF_RATE_DEF      = 521;
    localparam int unsigned BITS_PER_FRAME_DEF = 8;

    function automatic logic [7:0] frame_mask(input int unsigned bits);
        return 8'hFF >> (8 - bits);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: 16-bit counter with synchronous clear and a one-cycle tick
// at terminal count BAUD_RATE-1, after which it wraps to zero.
import uart_pkg::*;

module uart_baud_gen #(
    parameter int unsigned BAUD_RATE = BAUD_RATE_DEF
) (
    input  logic clk,
    input  logic rst_,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] TERM = 16'(BAUD_RATE - 1);

    logic [15:0] count;

    assign tick = enable && (count == TERM);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (enable) begin
            count <= tick ? 16'd0 : count + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default: valid/busy byte intake, LSB-first shift-out on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
import uart_pkg::*;

module uart_tx #(
    parameter int unsigned BAUD_RATE      = BAUD_RATE_DEF,
    parameter int unsigned BITS_PER_FRAME = BITS_PER_FRAME_DEF
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_BIT = 4'(BITS_PER_FRAME - 1);
    localparam logic [7:0] MASK     = frame_mask(BITS_PER_FRAME);

    uart_state_t state, state_next;
    logic [7:0]  shift_reg, shift_next;
    logic [3:0]  bit_cnt, bit_cnt_next;
    logic        tx_next, busy_next, done_next;
    logic        accept;
    logic        tick;
`ifdef UART_TX_PARITY_EN
    logic        parity_reg, parity_next;
`endif

    uart_baud_gen #(
        .BAUD_RATE(BAUD_RATE)
    ) u_baud_gen (
        .clk   (clk),
        .rst_  (rst_),
        .clear (accept),
        .enable(state != ST_IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        done_next    = 1'b0;
        accept       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state)
            ST_IDLE: begin
                if (din_valid && !busy) begin
                    accept       = 1'b1;
                    shift_next   = din & MASK;
                    bit_cnt_next = 4'd0;
                    state_next   = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_next  = ^(din & MASK);
`endif
                end
            end
            ST_START: begin
                if (tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // tx is decoded from the next state so the line is registered yet changes on the transition edge.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next = parity_reg;
`endif
            default:   tx_next = 1'b1;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= ST_IDLE;
            shift_reg <= 8'd0;
            bit_cnt   <= 4'd0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            tx        <= tx_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end
`endif

endmodule
